// File: rtl/usb_line_pkg.sv
// Shared definitions for the USB transmit line encoder.
//   - line_state_e : transmitter FSM states
//   - SYNC_PATTERN : SYNC byte sent LSB first (seven 0s then a 1)
//   - LINE_SE0, line_j(), line_k() : {D+, D-} drive levels
package usb_line_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StData,
    StEopSe0,
    StEopJ
  } line_state_e;

  localparam logic [7:0] SYNC_PATTERN = 8'h80;

  localparam logic [1:0] LINE_SE0 = 2'b00;

  // J and K depend on which polarity the bus idles in.
  function automatic logic [1:0] line_j(input logic j_dp);
    return {j_dp, ~j_dp};
  endfunction

  function automatic logic [1:0] line_k(input logic j_dp);
    return {~j_dp, j_dp};
  endfunction

endpackage

// File: rtl/usb_bit_stuffer.sv
// Bit stuffer and NRZI toggle register.
//   clk_i        : clock
//   rst_i        : synchronous active-high reset
//   clear_i      : return to J with an empty stuff count (end of packet)
//   send_i       : a bit-time is transmitted this cycle
//   data_bit_i   : data bit offered for this bit-time
//   stuff_o      : this bit-time carries a stuffed 0; the data bit is not consumed
//   level_next_o : D+ level that the line takes after this cycle
module usb_bit_stuffer
  import usb_line_pkg::*;
#(
  parameter int unsigned StuffLen = 6,
  parameter bit          JDp      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic send_i,
  input  logic data_bit_i,
  output logic stuff_o,
  output logic level_next_o
);

  localparam int unsigned CntW = $clog2(StuffLen + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            tx_bit;

  assign stuff_o = (cnt_q == CntW'(StuffLen));

  always_comb begin
    tx_bit  = stuff_o ? 1'b0 : data_bit_i;
    cnt_d   = cnt_q;
    level_d = level_q;
    if (clear_i) begin
      cnt_d   = '0;
      level_d = JDp;
    end else if (send_i) begin
      if (tx_bit) begin
        cnt_d = cnt_q + CntW'(1);
      end else begin
        // NRZI: a 0 is a transition.
        cnt_d   = '0;
        level_d = ~level_q;
      end
    end
  end

  assign level_next_o = level_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      level_q <= JDp;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/usb_tx_line_encoder.sv
// USB full/low-speed transmit line encoder: arbitrates N_CH byte sources, serialises the
// owner's bytes LSB first with bit stuffing and NRZI, and closes each packet with EOP.
// Optional feature macro: USB_TX_SYNC_EN (block inserts the SYNC byte itself).
//   useClk    : clock; everything advances on the rising edge
//   rst       : synchronous active-high reset
//   checkData : bit-time strobe; nothing but the one-cycle pulses changes without it
//   srcValid/srcData/srcLast : per-source byte stream (source i at srcData[8i+7:8i])
//   srcReady  : one-cycle pulse to the owner when its byte is taken
//   grant     : one-hot packet owner, zero when idle
//   NRZI/NRZI_not/OE : D+/D- drive levels and driver enable
//   underrun  : one-cycle pulse when a packet is cut short by a missing byte
module usb_tx_line_encoder
  import usb_line_pkg::*;
#(
  parameter int unsigned N_CH         = 5,
  parameter int unsigned EOP_SE0_BITS = 2,
  parameter int unsigned STUFF_LEN    = 6,
  parameter bit          J_DP         = 1'b0
) (
  input  logic                useClk,
  input  logic                rst,
  input  logic                checkData,
  input  logic [N_CH-1:0]     srcValid,
  input  logic [8*N_CH-1:0]   srcData,
  input  logic [N_CH-1:0]     srcLast,
  output logic [N_CH-1:0]     srcReady,
  output logic [N_CH-1:0]     grant,
  output logic                NRZI,
  output logic                NRZI_not,
  output logic                OE,
  output logic                underrun
);

  line_state_e     state_q, state_d;
  logic [N_CH-1:0] grant_q, grant_d;
  logic [N_CH-1:0] src_ready_q, src_ready_d;
  logic [7:0]      shift_q, shift_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;  // next bit index; 8 means byte stream finished
  logic            last_q, last_d;
  logic [2:0]      eop_cnt_q, eop_cnt_d;
  logic            underrun_q, underrun_d;
  logic            nrzi_q, nrzi_d;
  logic            nrzi_not_q, nrzi_not_d;
  logic            oe_q, oe_d;

  logic [N_CH-1:0] req_oh, sel_oh;
  logic [7:0]      sel_data;
  logic            sel_last, sel_valid;
  logic            st_send, st_bit, st_clear, stuff, level_next;

  // Lowest-index requester wins.
  assign req_oh = srcValid & (~srcValid + N_CH'(1));
  assign sel_oh = (state_q == StIdle) ? req_oh : grant_q;

  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (sel_oh[i]) begin
        sel_data  = srcData[8*i +: 8];
        sel_last  = srcLast[i];
        sel_valid = srcValid[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    last_d      = last_q;
    eop_cnt_d   = eop_cnt_q;
    src_ready_d = '0;
    underrun_d  = 1'b0;
    st_send     = 1'b0;
    st_bit      = 1'b0;
    st_clear    = 1'b0;
    if (checkData) begin
      unique case (state_q)
        StIdle: begin
          if (|srcValid) begin
            grant_d     = req_oh;
            src_ready_d = req_oh;
            shift_d     = sel_data;
            last_d      = sel_last;
            bit_cnt_d   = 4'd1;
            st_send     = 1'b1;
`ifdef USB_TX_SYNC_EN
            state_d     = StSync;
            st_bit      = SYNC_PATTERN[0];
`else
            state_d     = StData;
            st_bit      = sel_data[0];
`endif
          end
        end
`ifdef USB_TX_SYNC_EN
        StSync: begin
          st_send = 1'b1;
          st_bit  = SYNC_PATTERN[bit_cnt_q[2:0]];
          if (!stuff) begin
            if (bit_cnt_q == 4'd7) begin
              state_d   = StData;
              bit_cnt_d = 4'd0;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
`endif
        StData: begin
          if (bit_cnt_q[3] && !stuff) begin
            state_d   = StEopSe0;
            eop_cnt_d = 3'd1;
          end else begin
            // A pending stuff bit goes out even after the final data bit.
            st_send = 1'b1;
            st_bit  = shift_q[bit_cnt_q[2:0]];
            if (!stuff && !bit_cnt_q[3]) begin
              if (bit_cnt_q == 4'd7) begin
                if (!last_q && sel_valid) begin
                  shift_d     = sel_data;
                  last_d      = sel_last;
                  bit_cnt_d   = 4'd0;
                  src_ready_d = grant_q;
                end else begin
                  bit_cnt_d  = 4'd8;
                  underrun_d = ~last_q;
                end
              end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
              end
            end
          end
        end
        StEopSe0: begin
          st_clear = 1'b1;
          if (eop_cnt_q == 3'(EOP_SE0_BITS)) begin
            state_d = StEopJ;
          end else begin
            eop_cnt_d = eop_cnt_q + 3'd1;
          end
        end
        StEopJ: begin
          st_clear = 1'b1;
          state_d  = StIdle;
          grant_d  = '0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Line drive follows the state being entered so outputs change exactly on strobes.
  always_comb begin
    unique case (state_d)
      StSync, StData: begin
        nrzi_d     = level_next;
        nrzi_not_d = ~level_next;
        oe_d       = 1'b1;
      end
      StEopSe0: begin
        {nrzi_d, nrzi_not_d} = LINE_SE0;
        oe_d                 = 1'b1;
      end
      StEopJ: begin
        {nrzi_d, nrzi_not_d} = line_j(J_DP);
        oe_d                 = 1'b1;
      end
      default: begin
        {nrzi_d, nrzi_not_d} = line_j(J_DP);
        oe_d                 = 1'b0;
      end
    endcase
  end

  usb_bit_stuffer #(
    .StuffLen (STUFF_LEN),
    .JDp      (J_DP)
  ) u_stuffer (
    .clk_i        (useClk),
    .rst_i        (rst),
    .clear_i      (st_clear),
    .send_i       (st_send),
    .data_bit_i   (st_bit),
    .stuff_o      (stuff),
    .level_next_o (level_next)
  );

  always_ff @(posedge useClk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      src_ready_q <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      last_q      <= 1'b0;
      eop_cnt_q   <= '0;
      underrun_q  <= 1'b0;
      nrzi_q      <= J_DP;
      nrzi_not_q  <= ~J_DP;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      src_ready_q <= src_ready_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      last_q      <= last_d;
      eop_cnt_q   <= eop_cnt_d;
      underrun_q  <= underrun_d;
      nrzi_q      <= nrzi_d;
      nrzi_not_q  <= nrzi_not_d;
      oe_q        <= oe_d;
    end
  end

  assign srcReady = src_ready_q;
  assign grant    = grant_q;
  assign NRZI     = nrzi_q;
  assign NRZI_not = nrzi_not_q;
  assign OE       = oe_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Directed bench for usb_tx_line_encoder. Expected line symbols per strobe are written by
// hand: K/J = NRZI level, 0 = SE0 (all with OE=1), I = idle J with OE=0. Without
// USB_TX_SYNC_EN the bench supplies the SYNC byte itself, so the line is the same.
module tb_usb_tx_line_encoder;

  localparam int unsigned N_CH = 5;
  localparam bit          J_DP = 1'b0;

  logic                useClk = 1'b0;
  logic                rst;
  logic                checkData;
  logic [N_CH-1:0]     srcValid, srcLast, srcReady, grant;
  logic [8*N_CH-1:0]   srcData;
  logic                NRZI, NRZI_not, OE, underrun;

  int errors = 0;
  int checks = 0;

  logic [7:0] src_bytes [N_CH][8];
  int         src_len [N_CH];
  int         src_ptr [N_CH];
  logic       src_open [N_CH];  // packet deliberately lacks a last byte

  always #5 useClk = ~useClk;

  usb_tx_line_encoder #(
    .N_CH         (N_CH),
    .EOP_SE0_BITS (2),
    .STUFF_LEN    (6),
    .J_DP         (J_DP)
  ) dut (
    .useClk    (useClk),
    .rst       (rst),
    .checkData (checkData),
    .srcValid  (srcValid),
    .srcData   (srcData),
    .srcLast   (srcLast),
    .srcReady  (srcReady),
    .grant     (grant),
    .NRZI      (NRZI),
    .NRZI_not  (NRZI_not),
    .OE        (OE),
    .underrun  (underrun)
  );

  task automatic drive_src();
    for (int i = 0; i < int'(N_CH); i++) begin
      if (src_ptr[i] < src_len[i]) begin
        srcValid[i]       = 1'b1;
        srcLast[i]        = !src_open[i] && (src_ptr[i] == src_len[i] - 1);
        srcData[8*i +: 8] = src_bytes[i][src_ptr[i]];
      end else begin
        srcValid[i]       = 1'b0;
        srcLast[i]        = 1'b0;
        srcData[8*i +: 8] = 8'h00;
      end
    end
  endtask

  task automatic start_pkt(input int ch);
    src_len[ch]  = 0;
    src_ptr[ch]  = 0;
    src_open[ch] = 1'b0;
`ifndef USB_TX_SYNC_EN
    src_bytes[ch][0] = 8'h80;
    src_len[ch]      = 1;
`endif
  endtask

  task automatic add_byte(input int ch, input logic [7:0] b);
    src_bytes[ch][src_len[ch]] = b;
    src_len[ch]++;
  endtask

  // One clock; a source advances to its next byte after it sees srcReady.
  task automatic tick(input logic cd);
    checkData = cd;
    @(posedge useClk);
    #1;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (srcReady[i] && src_ptr[i] < src_len[i]) src_ptr[i]++;
    end
    drive_src();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] sym(input byte c);
    case (c)
      "K":     return {~J_DP, J_DP, 1'b1};
      "J":     return {J_DP, ~J_DP, 1'b1};
      "0":     return 3'b001;
      default: return {J_DP, ~J_DP, 1'b0};
    endcase
  endfunction

  // Strobes through a whole packet, then checks the return to idle.
  task automatic check_line(input string tag, input string exp, input logic [N_CH-1:0] gexp,
                            input int ur_idx, input int gap);
    for (int k = 0; k < exp.len(); k++) begin
      tick(1'b1);
      check($sformatf("%s line[%0d]", tag, k), 32'({NRZI, NRZI_not, OE}), 32'(sym(exp[k])));
      check($sformatf("%s grant[%0d]", tag, k), 32'(grant), 32'(gexp));
      check($sformatf("%s underrun[%0d]", tag, k), 32'(underrun), 32'(k == ur_idx));
      for (int g = 0; g < gap; g++) begin
        tick(1'b0);
        check($sformatf("%s hold[%0d.%0d]", tag, k, g), 32'({NRZI, NRZI_not, OE}),
              32'(sym(exp[k])));
      end
    end
    tick(1'b1);
    check({tag, " idle line"}, 32'({NRZI, NRZI_not, OE}), 32'(sym("I")));
    check({tag, " idle grant"}, 32'(grant), 32'd0);
  endtask

  localparam string PktD2    = "KJKJKJKKJJKJJKKK00J";
  localparam string PktFfFf  = "KJKJKJKKKKKKKJJJJJJJKKKKKK00J";

  initial begin
    rst       = 1'b1;
    checkData = 1'b0;
    for (int i = 0; i < int'(N_CH); i++) begin
      src_len[i]  = 0;
      src_ptr[i]  = 0;
      src_open[i] = 1'b0;
    end
    drive_src();
    tick(1'b0);
    tick(1'b1);
    check("reset line", 32'({NRZI, NRZI_not, OE}), 32'(sym("I")));
    check("reset grant", 32'(grant), 32'd0);
    check("reset ready", 32'(srcReady), 32'd0);
    check("reset underrun", 32'(underrun), 32'd0);
    rst = 1'b0;
    tick(1'b1);
    check("idle no request", 32'({NRZI, NRZI_not, OE}), 32'(sym("I")));

    // Single-byte packet 0xD2.
    start_pkt(0);
    add_byte(0, 8'hD2);
    drive_src();
    check_line("d2", PktD2, 5'b00001, -1, 0);

    // Stuffing across the byte boundary.
    start_pkt(0);
    add_byte(0, 8'hFF);
    add_byte(0, 8'hFF);
    drive_src();
    check_line("stuff", PktFfFf, 5'b00001, -1, 0);

    // Two simultaneous requesters; lower index first, no pre-emption.
    start_pkt(1);
    add_byte(1, 8'hD2);
    start_pkt(3);
    add_byte(3, 8'hD2);
    drive_src();
    check_line("arb1", PktD2, 5'b00010, -1, 0);
    check_line("arb3", PktD2, 5'b01000, -1, 0);

    // Byte stream stops without a last byte.
    start_pkt(0);
    add_byte(0, 8'hD2);
    src_open[0] = 1'b1;
    drive_src();
    check_line("urun", PktD2, 5'b00001, 15, 0);

    // Reset in the middle of the third byte on the line.
    start_pkt(0);
    for (int b = 0; b < 4; b++) add_byte(0, 8'h00);
    drive_src();
    for (int s = 0; s < 27; s++) tick(1'b1);
    check("midpkt oe", 32'(OE), 32'd1);
    rst = 1'b1;
    tick(1'b1);
    check("rst line", 32'({NRZI, NRZI_not, OE}), 32'(sym("I")));
    check("rst grant", 32'(grant), 32'd0);
    check("rst ready", 32'(srcReady), 32'd0);
    rst = 1'b0;
    src_len[0] = 0;
    src_ptr[0] = 0;
    drive_src();
    tick(1'b1);
    check("post rst idle", 32'({NRZI, NRZI_not, OE}), 32'(sym("I")));
    start_pkt(0);
    add_byte(0, 8'hD2);
    drive_src();
    check_line("fresh", PktD2, 5'b00001, -1, 0);

    // Strobe once every four cycles.
    start_pkt(0);
    add_byte(0, 8'hD2);
    drive_src();
    check_line("slow", PktD2, 5'b00001, -1, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
